pipemem_dbus: RTL and testbench

- MEM-stage data-bus unit. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns load/store requests into a req/ack data-bus transaction with byte enables.
- Extracts and extends load data into mmo, and stalls the pipeline while the bus is busy.
- Flags misaligned accesses without issuing a bus cycle.

---
 rtl/pipemem_dbus_pkg.sv | 59 +++++
 rtl/pipemem_dbus_if.sv | 17 +
 rtl/pipemem_ldext.sv | 28 ++
 rtl/pipemem_dbus.sv | 123 ++++++++++++
 tb/tb_pipemem_dbus.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipemem_dbus_pkg.sv
// Shared types for the MEM-stage data-bus unit: FSM states, access sizes,
// byte-enable patterns and the store-lane helper.
package pipemem_dbus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_MIS  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [BEN_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BEN_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BEN_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BEN_W-1:0] BE_WORD    = 4'b1111;

  typedef struct packed {
    logic [BEN_W-1:0]  be;
    logic [DATA_W-1:0] wdata;
  } st_lane_t;

  // Byte enables plus lane-replicated store data; size 2'b11 behaves as a word.
  function automatic st_lane_t store_lanes(input logic [1:0] size,
                                           input logic [1:0] off,
                                           input logic [DATA_W-1:0] data);
    st_lane_t l;
    case (size)
      SZ_B: begin
        l.be    = BE_BYTE0 << off;
        l.wdata = {4{data[7:0]}};
      end
      SZ_H: begin
        l.be    = off[1] ? BE_HALF_HI : BE_HALF_LO;
        l.wdata = {2{data[15:0]}};
      end
      default: begin
        l.be    = BE_WORD;
        l.wdata = data;
      end
    endcase
    return l;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pipemem_dbus_if.sv
// Data-bus req/ack channel between the MEM stage (master) and memory (slave).
interface pipemem_dbus_if
  import pipemem_dbus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BEN_W-1:0]  be;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/pipemem_ldext.sv
// Load-data lane select and sign/zero extension; purely combinational so a
// later cache read path can reuse it.
module pipemem_ldext
  import pipemem_dbus_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [DATA_W-1:0] data_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{off, 3'b000} +: 8];
  assign lane_h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data_c = rdata;
    case (size)
      SZ_B:    data_c = {{24{sgn & lane_b[7]}}, lane_b};
      SZ_H:    data_c = {{16{sgn & lane_h[15]}}, lane_h};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/pipemem_dbus.sv
// MEM-stage data-bus unit: issues req/ack bus cycles for loads/stores, stalls
// the pipeline while busy, flags misalignment. Build option PIPEMEM_TIMEOUT_EN
// adds a bus-error abort after TIMEOUT_CYC unacknowledged request cycles.
module pipemem_dbus
  import pipemem_dbus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
`ifdef PIPEMEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       malu,
  input  logic [31:0]       mb,
  input  logic              mwmem,
  input  logic              mm2reg,
  input  logic [1:0]        msize,
  input  logic              msigned,
  output logic [31:0]       mmo,
  output logic              mstall,
  output logic              mexc_misalign,
  output logic              mexc_buserr,
  pipemem_dbus_if.master    dbus
);

  state_e            state;
  logic              acc;
  logic              misal_c;
  st_lane_t          lane_c;
  logic [1:0]        ld_off;
  logic [1:0]        ld_size;
  logic              ld_sgn;
  logic [DATA_W-1:0] ld_data_c;

`ifdef PIPEMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign acc     = mwmem | mm2reg;
  assign misal_c = misaligned(msize, malu[1:0]);
  assign lane_c  = store_lanes(msize, malu[1:0], mb);

  // Stall from registered state: low in DONE/MIS so MEM/WB captures mmo.
  assign mstall = acc & ((state == ST_IDLE) | (state == ST_REQ));

  // Extraction uses the lane info latched at request time.
  pipemem_ldext u_ldext (
    .rdata  (dbus.rdata),
    .off    (ld_off),
    .size   (ld_size),
    .sgn    (ld_sgn),
    .data_c (ld_data_c)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= ST_IDLE;
      mmo           <= '0;
      mexc_misalign <= 1'b0;
      mexc_buserr   <= 1'b0;
      dbus.req      <= 1'b0;
      dbus.we       <= 1'b0;
      dbus.addr     <= '0;
      dbus.be       <= '0;
      dbus.wdata    <= '0;
      ld_off        <= '0;
      ld_size       <= SZ_B;
      ld_sgn        <= 1'b0;
`ifdef PIPEMEM_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      mexc_misalign <= 1'b0;
      mexc_buserr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc && misal_c) begin
            state         <= ST_MIS;
            mexc_misalign <= 1'b1;
            mmo           <= '0;
          end else if (acc) begin
            state      <= ST_REQ;
            dbus.req   <= 1'b1;
            dbus.we    <= mwmem;
            dbus.addr  <= {malu[ADDR_W-1:2], 2'b00};
            dbus.be    <= lane_c.be;
            dbus.wdata <= lane_c.wdata;
            ld_off     <= malu[1:0];
            ld_size    <= msize;
            ld_sgn     <= msigned;
`ifdef PIPEMEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (dbus.ack) begin
            state    <= ST_DONE;
            dbus.req <= 1'b0;
            if (!dbus.we) mmo <= ld_data_c;
          end
`ifdef PIPEMEM_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state       <= ST_DONE;
            dbus.req    <= 1'b0;
            mexc_buserr <= 1'b1;
            mmo         <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE: state <= ST_IDLE;
        ST_MIS:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipemem_dbus.sv
// Bench for pipemem_dbus: per-access expected cycle scripts from a
// transaction-level model, compared every cycle, plus directed literal pins.
module tb_pipemem_dbus;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] malu, mb;
  logic        mwmem, mm2reg, msigned;
  logic [1:0]  msize;
  logic [31:0] mmo;
  logic        mstall, mexc_misalign, mexc_buserr;

  pipemem_dbus_if #(.ADDR_W(32)) dbus ();

`ifdef PIPEMEM_TIMEOUT_EN
  localparam int TO   = 4;
  localparam int WMAX = 6;
`else
  localparam int WMAX = 5;
`endif

  pipemem_dbus #(
    .ADDR_W(32)
`ifdef PIPEMEM_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk           (clk),
    .clrn          (clrn),
    .malu          (malu),
    .mb            (mb),
    .mwmem         (mwmem),
    .mm2reg        (mm2reg),
    .msize         (msize),
    .msigned       (msigned),
    .mmo           (mmo),
    .mstall        (mstall),
    .mexc_misalign (mexc_misalign),
    .mexc_buserr   (mexc_buserr),
    .dbus          (dbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        bus;
    logic        wd;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;
    logic        mis;
    logic        berr;
    logic [31:0] mmo;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          acc_id = 0;
  logic [31:0] m_mmo;
  int          req_cycles, stall_cycles, mis_cnt, berr_cnt;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic        seen_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s access=%0d got=%h want=%h", nm, acc_id, act, want);
    end
  endtask

  // ---- transaction-level model ----
  function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'(1 << off);
      2'd1:    return off[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return 32'(d[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                         input logic sg, input logic [31:0] rd);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (rd >> (16 * off[1])) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic exp_t mk(input logic req, input logic stall, input logic mis, input logic berr);
    exp_t e;
    e.req = req; e.bus = 1'b0; e.wd = 1'b0; e.we = 1'b0; e.addr = '0; e.be = '0; e.wdata = '0;
    e.stall = stall; e.mis = mis; e.berr = berr; e.mmo = m_mmo;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scripts one access cycle by cycle; the slave acks after 'waits' REQ cycles.
  task automatic do_access(input logic st, input logic ld, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] d, input logic [31:0] rd, input int waits);
    exp_t e;
    logic tmo;
    int   i;
    acc_id++;
    req_cycles = 0; stall_cycles = 0; mis_cnt = 0; berr_cnt = 0;
    malu = a; mb = d; mwmem = st; mm2reg = ld; msize = sz; msigned = sg;
    dbus.ack = ($urandom_range(0, 3) == 0);
    dbus.rdata = $urandom;
    if (!(st | ld)) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      step();
      return;
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    step();
    if (m_misal(sz, a)) begin
      m_mmo = '0;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      dbus.ack = 1'($urandom_range(0, 1));
      step();
      return;
    end
    tmo = 1'b0;
    i = 0;
    forever begin
      dbus.ack = (i == waits);
      dbus.rdata = (i == waits) ? rd : $urandom;
      e = mk(1'b1, 1'b1, 1'b0, 1'b0);
      e.bus = 1'b1; e.wd = st; e.we = st; e.addr = a & 32'hFFFF_FFFC;
      e.be = m_be(sz, a[1:0]); e.wdata = m_wdata(sz, d);
      exp_q.push_back(e);
      step();
      if (i == waits) break;
`ifdef PIPEMEM_TIMEOUT_EN
      if (i == TO - 1) begin
        tmo = 1'b1;
        break;
      end
`endif
      i++;
    end
    if (tmo) m_mmo = '0;
    else if (!st) m_mmo = m_load(sz, a[1:0], sg, rd);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, tmo));
    dbus.ack = 1'($urandom_range(0, 1));
    dbus.rdata = $urandom;
    step();
  endtask

  task automatic idle_pin();
    mwmem = 1'b0; mm2reg = 1'b0; dbus.ack = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
  endtask

  // Single compare process: every cycle against the scripted expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dbus.req === 1'b1) begin
        req_cycles++;
        seen_be = dbus.be; seen_wdata = dbus.wdata; seen_we = dbus.we;
      end
      if (mstall === 1'b1) stall_cycles++;
      if (mexc_misalign === 1'b1) mis_cnt++;
      if (mexc_buserr === 1'b1) berr_cnt++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dbus_req", 32'(dbus.req), 32'(e.req));
        chk("mstall", 32'(mstall), 32'(e.stall));
        chk("mexc_misalign", 32'(mexc_misalign), 32'(e.mis));
        chk("mexc_buserr", 32'(mexc_buserr), 32'(e.berr));
        chk("mmo", mmo, e.mmo);
        if (e.bus) begin
          chk("dbus_we", 32'(dbus.we), 32'(e.we));
          chk("dbus_addr", dbus.addr, e.addr);
          chk("dbus_be", 32'(dbus.be), 32'(e.be));
          if (e.wd) chk("dbus_wdata", dbus.wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    exp_t e;
    clrn = 1'b0; malu = '0; mb = '0; mwmem = 1'b0; mm2reg = 1'b0; msize = '0; msigned = 1'b0;
    dbus.ack = 1'b0; dbus.rdata = '0; m_mmo = '0;
    req_cycles = 0; stall_cycles = 0; mis_cnt = 0; berr_cnt = 0;
    seen_be = '0; seen_wdata = '0; seen_we = 1'b0;
    @(posedge clk);
    #1;
    e = mk(1'b0, 1'b0, 1'b0, 1'b0); e.bus = 1'b1; e.wd = 1'b1;
    exp_q.push_back(e);
    step();
    clrn = 1'b1;

    // word load, two wait states
    do_access(1'b0, 1'b1, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 2);
    idle_pin();
    chk("wl_req_cycles", 32'(req_cycles), 32'd3);
    chk("wl_stall_cycles", 32'(stall_cycles), 32'd4);
    chk("wl_be", 32'(seen_be), 32'hF);
    chk("wl_mmo", mmo, 32'hDEAD_BEEF);
    step();

    // byte loads at lane 3, signed then unsigned
    do_access(1'b0, 1'b1, 32'h103, 2'b00, 1'b1, 32'h0, 32'h80FF_1234, 0);
    idle_pin();
    chk("lb_be", 32'(seen_be), 32'h8);
    chk("lb_mmo", mmo, 32'hFFFF_FF80);
    step();
    do_access(1'b0, 1'b1, 32'h103, 2'b00, 1'b0, 32'h0, 32'h80FF_1234, 1);
    idle_pin();
    chk("lbu_mmo", mmo, 32'h0000_0080);
    step();

    // half store on the upper lane
    do_access(1'b1, 1'b0, 32'h102, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0, 1);
    idle_pin();
    chk("sh_we", 32'(seen_we), 32'd1);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    chk("sh_mmo", mmo, 32'h0000_0080);
    step();

    // misaligned word load
    do_access(1'b0, 1'b1, 32'h101, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 0);
    idle_pin();
    chk("mis_pulses", 32'(mis_cnt), 32'd1);
    chk("mis_req_cycles", 32'(req_cycles), 32'd0);
    chk("mis_mmo", mmo, 32'h0);
    step();

    // back-to-back store then load, zero wait
    do_access(1'b1, 1'b0, 32'h40, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 0);
    do_access(1'b0, 1'b1, 32'h46, 2'b01, 1'b1, 32'h0, 32'h8001_0000, 0);
    idle_pin();
    chk("b2b_req_cycles", 32'(req_cycles), 32'd1);
    chk("b2b_stall_cycles", 32'(stall_cycles), 32'd2);
    chk("b2b_mmo", mmo, 32'hFFFF_8001);
    step();

    // reset asserted while a request is outstanding
    acc_id++;
    malu = 32'h200; mb = '0; mwmem = 1'b0; mm2reg = 1'b1; msize = 2'b10; msigned = 1'b0; dbus.ack = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    step();
    e = mk(1'b1, 1'b1, 1'b0, 1'b0); e.bus = 1'b1; e.addr = 32'h200; e.be = 4'hF;
    exp_q.push_back(e);
    step();
    clrn = 1'b0; mm2reg = 1'b0; m_mmo = '0;
    e = mk(1'b0, 1'b0, 1'b0, 1'b0); e.bus = 1'b1; e.wd = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(dbus.req), 32'd0);
    chk("rst_mmo", mmo, 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    exp_q.push_back(e);
    step();

`ifdef PIPEMEM_TIMEOUT_EN
    // unanswered request aborts with a bus error
    do_access(1'b0, 1'b1, 32'h304, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 1);
    do_access(1'b0, 1'b1, 32'h300, 2'b10, 1'b0, 32'h0, 32'h5555_5555, 1000);
    idle_pin();
    chk("to_req_cycles", 32'(req_cycles), 32'd4);
    chk("to_berr_pulses", 32'(berr_cnt), 32'd1);
    chk("to_mmo", mmo, 32'd0);
    step();
`endif

    for (int n = 0; n < 400; n++) begin
      int          k;
      logic        st, ld;
      logic [31:0] a;
      k  = $urandom_range(0, 19);
      st = (k >= 2 && k < 10) || k == 19;
      ld = (k >= 10);
      a  = $urandom;
      if (k % 3 == 0) a[1:0] = 2'b00;
      do_access(st, ld, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom_range(0, WMAX));
    end

    idle_pin();
    step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
